fb_writer: RTL and testbench

FB_WRITER -- requirements
Module: fb_writer

---
 rtl/fb_writer.sv | 178 +++++++++++++++++
 tb/tb_fb_writer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_writer.sv
// fb_writer: buffers on-screen PPU pixels in a small FIFO and drains them to
// the framebuffer one write at a time over a level request / pulse ack port.
// It also back-pressures the tick generator, flags lost pixels and marks the
// end of each frame.
module fb_writer #(
    parameter int          DEPTH = 16,
    parameter logic [21:0] BASE  = 22'h000000,
    parameter int          HIWAT = DEPTH - 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  outx,
    input  logic [8:0]  outy,
    input  logic        pxvalid,
    input  logic [23:0] pix,
    output logic        stall,
    output logic [21:0] fbaddr,
    output logic [23:0] fbdata,
    output logic        fbreq,
    input  logic        fback,
    output logic        frame,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 40;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nx_s;
    logic [EW-1:0]   mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;

    logic            in_win_s;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic            drop_s;
    logic            load_s;
    logic [EW-1:0]   head_s;
    logic [21:0]     addr_s;
    logic            last_px_s;

    // Pixel window qualification and FIFO push/drop decisions.
    always_comb begin
        in_win_s = pxvalid && (outx < 9'd256) && (outy < 9'd240);
        full_s   = (count_r == CW'(DEPTH));
        empty_s  = (count_r == {CW{1'b0}});
        // A pop on this edge frees a slot, so a full FIFO can still take the pixel.
        push_s   = in_win_s && (!full_s || pop_s);
        drop_s   = in_win_s && full_s && !pop_s;
    end

    // FIFO head decode: entry layout is {y[7:0], x[7:0], pix}.
    always_comb begin
        head_s    = mem_r[rd_ptr_r];
        addr_s    = BASE + {6'b000000, head_s[39:32], head_s[31:24]};
        last_px_s = (head_s[39:32] == 8'd239) && (head_s[31:24] == 8'd255);
    end

    // Write FSM next-state: IDLE loads a write from the head, REQ waits for ack.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    load_s     = 1'b1;
                    state_nx_s = REQ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            REQ: begin
                if (fback) begin
                    pop_s      = 1'b1;
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = REQ;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {outy[7:0], outx[7:0], pix};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Framebuffer write port; address and data hold their last value between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fbreq  <= 1'b0;
            fbaddr <= 22'h000000;
            fbdata <= 24'h000000;
        end else if (load_s) begin
            fbreq  <= 1'b1;
            fbaddr <= addr_s;
            fbdata <= head_s[23:0];
        end else if (pop_s) begin
            fbreq  <= 1'b0;
        end
    end

    // End-of-frame pulse follows the acknowledged write of the last pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame <= 1'b0;
        end else begin
            frame <= pop_s && last_px_s;
        end
    end

    // Back-pressure is registered from the current occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall <= 1'b0;
        end else begin
            stall <= (count_r >= CW'(HIWAT));
        end
    end

    // Sticky pixel-loss flag; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop_s) begin
            overflow <= 1'b1;
        end else begin
            overflow <= overflow;
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer: directed pixels push expected writes into a
// queue; a monitor compares each new framebuffer request against the queue.
module tb_fb_writer;

    localparam logic [21:0] BASE_B = 22'h3FFF00;

    logic        clk;
    logic        reset;
    logic [8:0]  outx;
    logic [8:0]  outy;
    logic        pxvalid;
    logic [23:0] pix;
    logic        fback;
    logic        stall, fbreq, frame, overflow;
    logic [21:0] fbaddr;
    logic [23:0] fbdata;
    logic        stall2, fbreq2, frame2, overflow2;
    logic [21:0] fbaddr2;
    logic [23:0] fbdata2;

    fb_writer u_dut (
        .clk(clk), .reset(reset), .outx(outx), .outy(outy), .pxvalid(pxvalid),
        .pix(pix), .stall(stall), .fbaddr(fbaddr), .fbdata(fbdata), .fbreq(fbreq),
        .fback(fback), .frame(frame), .overflow(overflow)
    );

    fb_writer #(.BASE(BASE_B)) u_dut2 (
        .clk(clk), .reset(reset), .outx(outx), .outy(outy), .pxvalid(pxvalid),
        .pix(pix), .stall(stall2), .fbaddr(fbaddr2), .fbdata(fbdata2), .fbreq(fbreq2),
        .fback(fback), .frame(frame2), .overflow(overflow2)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [45:0] sb[$];
    bit          ack_en = 1'b0;
    int          ack_lat = 0;
    int          frame_cnt = 0;
    logic [21:0] last_addr = 22'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one pixel for one cycle; accepted pixels queue their expected write.
    task automatic px(input logic [8:0] x, input logic [8:0] y, input logic [23:0] c, input bit acc);
        outx = x; outy = y; pix = c; pxvalid = 1'b1;
        if (acc) sb.push_back({22'h0 + {6'd0, y[7:0], x[7:0]}, c});
        @(negedge clk);
        pxvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int b = 0;
        while (!(sb.size() == 0 && !fbreq && u_dut.count_r == 0) && b < budget) begin
            @(negedge clk);
            b++;
        end
        chk("drain_done", (sb.size() == 0 && !fbreq && u_dut.count_r == 0), 64'd1);
    endtask

    task automatic wait_req2(input int budget);
        int b = 0;
        while (!fbreq2 && b < budget) begin
            @(negedge clk);
            b++;
        end
        chk("req2_seen", fbreq2, 64'd1);
    endtask

    // Acknowledge responder: pulses fback ack_lat cycles after a request.
    initial begin
        int wcnt = 0;
        forever begin
            @(negedge clk);
            if (ack_en) begin
                if (fbreq && !fback) begin
                    if (wcnt >= ack_lat) begin
                        fback = 1'b1;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    fback = 1'b0;
                    wcnt = 0;
                end
            end
        end
    end

    // Monitor: compares each rising request with the scoreboard head, checks frame.
    initial begin
        logic prev_req = 1'b0;
        logic [21:0] ack_addr = 22'h3FFFFF;
        logic [45:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (frame) begin
                frame_cnt++;
                chk("frame_follows_last_ack", {42'd0, ack_addr}, 64'h00EFFF);
            end
            ack_addr = (fback && fbreq) ? fbaddr : 22'h3FFFFF;
            if (fbreq && !prev_req) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_write: got addr %0h data %0h, none expected", fbaddr, fbdata);
                end else begin
                    e = sb.pop_front();
                    chk("write_addr", {42'd0, fbaddr}, {42'd0, e[45:24]});
                    chk("write_data", {40'd0, fbdata}, {40'd0, e[23:0]});
                    last_addr = fbaddr;
                end
            end
            prev_req = fbreq;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; pxvalid = 1'b0; outx = 9'd0; outy = 9'd0; pix = 24'h0; fback = 1'b0;
        repeat (2) @(negedge clk);
        // Reset state, with pixels and ack presented while in reset.
        chk("rst_fbreq", fbreq, 64'd0);
        chk("rst_stall", stall, 64'd0);
        chk("rst_frame", frame, 64'd0);
        chk("rst_overflow", overflow, 64'd0);
        chk("rst_fbaddr", {42'd0, fbaddr}, 64'd0);
        chk("rst_fbdata", {40'd0, fbdata}, 64'd0);
        outx = 9'd1; outy = 9'd1; pxvalid = 1'b1; fback = 1'b1;
        repeat (2) @(negedge clk);
        pxvalid = 1'b0; fback = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ignore_px_count", {59'd0, u_dut.count_r}, 64'd0);
        chk("rst_ignore_px_req", fbreq, 64'd0);

        // Single pixel, ack two cycles after request.
        ack_en = 1'b1; ack_lat = 2;
        px(9'd3, 9'd2, 24'hABCDEF, 1'b1);
        @(negedge clk);
        chk("single_req", fbreq, 64'd1);
        chk("single_addr", {42'd0, fbaddr}, 64'h000203);
        chk("single_data", {40'd0, fbdata}, 64'hABCDEF);
        drain(50);
        chk("single_count0", {59'd0, u_dut.count_r}, 64'd0);
        chk("single_hold_addr", {42'd0, fbaddr}, 64'h000203);

        // Base address wrap on the second instance.
        ack_lat = 0;
        px(9'h010, 9'd1, 24'h123456, 1'b1);
        wait_req2(20);
        chk("wrap_addr", {42'd0, fbaddr2}, 64'h000010);
        drain(50);

        // Off-screen pixels are discarded.
        px(9'd256, 9'd0, 24'h111111, 1'b0);
        px(9'd0, 9'd240, 24'h222222, 1'b0);
        repeat (5) @(negedge clk);
        chk("offscreen_req", fbreq, 64'd0);
        chk("offscreen_count", {59'd0, u_dut.count_r}, 64'd0);

        // Fill with ack held off: stall, full, pop+push on the same edge, overflow.
        ack_en = 1'b0; fback = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            px(9'(k), 9'd5, 24'h100000 + 24'(k), 1'b1);
            if (k == 12) chk("stall_low_at_12", stall, 64'd0);
            if (k == 13) chk("stall_high_at_13", stall, 64'd1);
        end
        chk("full_count", {59'd0, u_dut.count_r}, 64'd16);
        chk("full_no_overflow", overflow, 64'd0);
        fback = 1'b1;
        px(9'd17, 9'd5, 24'h100011, 1'b1);
        fback = 1'b0;
        chk("poppush_count", {59'd0, u_dut.count_r}, 64'd16);
        chk("poppush_no_overflow", overflow, 64'd0);
        px(9'd18, 9'd5, 24'h100012, 1'b0);
        chk("ovf_set", overflow, 64'd1);
        chk("ovf_count", {59'd0, u_dut.count_r}, 64'd16);
        chk("ovf_req_held", fbreq, 64'd1);
        chk("ovf_stall", stall, 64'd1);
        ack_en = 1'b1; ack_lat = 0;
        drain(200);
        chk("ovf_sticky", overflow, 64'd1);
        chk("stall_released", stall, 64'd0);

        // Reset while a write is pending with entries queued.
        ack_en = 1'b0; fback = 1'b0;
        for (int k = 0; k < 5; k++) px(9'(40 + k), 9'd7, 24'h200000 + 24'(k), 1'b1);
        @(negedge clk);
        chk("pre_rst_req", fbreq, 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_req", fbreq, 64'd0);
        chk("async_rst_count", {59'd0, u_dut.count_r}, 64'd0);
        chk("async_rst_overflow", overflow, 64'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_rst_no_write", fbreq, 64'd0);

        // Frame tail: only the last pixel of the frame raises frame.
        ack_en = 1'b1; ack_lat = 0;
        px(9'd255, 9'd238, 24'h333333, 1'b1);
        for (int k = 250; k <= 255; k++) px(9'(k), 9'd239, 24'h400000 + 24'(k), 1'b1);
        drain(200);
        repeat (3) @(negedge clk);
        chk("frame_pulses", frame_cnt, 64'd1);
        chk("last_addr", {42'd0, last_addr}, 64'h00EFFF);
        chk("sb_empty", sb.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
